dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data RAM between the processor's load/store path (port A) and a second master such as a serial loader or debug reader (port B). It sits between the requesters and the RAM's address/data/wren/q pins, on the processor clock. Arbitration is round-robin with a bounded burst tenure. Read data returns in order, with the requester identity tracked through the RAM read latency.

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter for the single-port data RAM
// Bounded burst tenure; read responses are tagged with the requester through the RAM latency.
module dmem_arbiter #(
   parameter int N         = 8,
   parameter int AW        = 8,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_a,
   input  logic          req_b,
   input  logic          we_a,
   input  logic          we_b,
   input  logic [AW-1:0] addr_a,
   input  logic [AW-1:0] addr_b,
   input  logic [N-1:0]  wdata_a,
   input  logic [N-1:0]  wdata_b,
   output logic          gnt_a,
   output logic          gnt_b,
   output logic          rvalid_a,
   output logic          rvalid_b,
   output logic [N-1:0]  rdata,
   output logic [AW-1:0] ram_address,
   output logic [N-1:0]  ram_data,
   output logic          ram_wren,
   input  logic [N-1:0]  ram_q,
   output logic [1:0]    owner
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_A    = 2'b01;
   localparam logic [1:0] S_B    = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              last_q, last_d;   // 1 = port B served last
   logic              win_v, win_b, win_we;
   logic              burst_done;
   logic [RD_LAT-1:0] pv_q, pid_q;

   assign burst_done = (cnt_q >= CW'(MAX_BURST));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      win_v = 1'b0;
      win_b = 1'b0;
      case (state_q)
         S_A: begin
            if (req_a && (!burst_done || !req_b)) begin
               win_v = 1'b1;
            end else if (req_b) begin
               win_v = 1'b1;
               win_b = 1'b1;
            end
         end
         S_B: begin
            if (req_b && (!burst_done || !req_a)) begin
               win_v = 1'b1;
               win_b = 1'b1;
            end else if (req_a) begin
               win_v = 1'b1;
            end
         end
         default: begin
            if (req_a && req_b) begin
               win_v = 1'b1;
               win_b = ~last_q;
            end else if (req_a || req_b) begin
               win_v = 1'b1;
               win_b = req_b;
            end
         end
      endcase
      // Grants are forced off while reset is held, independent of req
      if (!rst) win_v = 1'b0;

      state_d = win_v ? (win_b ? S_B : S_A) : S_IDLE;
      if (!win_v)
         cnt_d = '0;
      else if (state_d == state_q)
         cnt_d = burst_done ? cnt_q : cnt_q + CW'(1);
      else
         cnt_d = CW'(1);
      last_d = last_q;
      if (state_q != S_IDLE && state_d != state_q)
         last_d = (state_q == S_B);
   end

   always_comb begin
      gnt_a       = win_v & ~win_b;
      gnt_b       = win_v & win_b;
      win_we      = win_b ? we_b : we_a;
      ram_wren    = win_v & win_we;
      ram_address = (win_v && win_b) ? addr_b : addr_a;
      ram_data    = (win_v && win_b) ? wdata_b : wdata_a;
      owner       = state_q;
   end

   // Read-tag pipeline: stage 0 is written on the accept edge, last stage lines up with ram_q
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pv_q  <= '0;
         pid_q <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            pv_q[i]  <= pv_q[i-1];
            pid_q[i] <= pid_q[i-1];
         end
         pv_q[0]  <= win_v & ~win_we;
         pid_q[0] <= win_b;
      end
   end

   assign rvalid_a = rst & pv_q[RD_LAT-1] & ~pid_q[RD_LAT-1];
   assign rvalid_b = rst & pv_q[RD_LAT-1] & pid_q[RD_LAT-1];
   assign rdata    = ram_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a transaction-level reference model
module tb_dmem_arbiter;
   localparam int N = 8, AW = 8, RD_LAT = 1, MB = 4;

   logic          clk = 1'b0, rst = 1'b0;
   logic          req_a = 0, req_b = 0, we_a = 0, we_b = 0;
   logic [AW-1:0] addr_a = 0, addr_b = 0;
   logic [N-1:0]  wdata_a = 0, wdata_b = 0;
   logic          gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wren;
   logic [N-1:0]  rdata, ram_data, ram_q;
   logic [AW-1:0] ram_address;
   logic [1:0]    owner;
   logic [N-1:0]  mem [256];

   int checks = 0, failures = 0;

   dmem_arbiter #(.N(N), .AW(AW), .RD_LAT(RD_LAT), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
      .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
      .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data),
      .ram_wren(ram_wren), .ram_q(ram_q), .owner(owner)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM, one cycle read latency
   always @(posedge clk) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   typedef struct {int due; int id; int data; bit known;} rsp_t;
   rsp_t expq[$];

   // Reference model: owner/last/cnt as plain integers, memory image and expected response queue
   initial begin
      int m_state, m_last, m_cnt, cyc, w;
      bit wr;
      int ad, dt;
      logic [N-1:0] mmem [256];
      bit known [256];
      rsp_t r;
      m_state = 0; m_last = 1; m_cnt = 0; cyc = 0;
      for (int i = 0; i < 256; i++) known[i] = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_state = 0; m_last = 1; m_cnt = 0;
            expq.delete();
            chk("rst_gnt_a", gnt_a, 0);
            chk("rst_gnt_b", gnt_b, 0);
            chk("rst_wren", ram_wren, 0);
            chk("rst_rvalid_a", rvalid_a, 0);
            chk("rst_rvalid_b", rvalid_b, 0);
            chk("rst_owner", owner, 0);
            @(posedge clk);
            cyc++;
            continue;
         end
         w = -1;
         if (m_state == 1) begin
            if (req_a && (m_cnt < MB || !req_b)) w = 0; else if (req_b) w = 1;
         end else if (m_state == 2) begin
            if (req_b && (m_cnt < MB || !req_a)) w = 1; else if (req_a) w = 0;
         end else begin
            if (req_a && req_b) w = (m_last == 1) ? 0 : 1;
            else if (req_a) w = 0;
            else if (req_b) w = 1;
         end
         wr = (w == 1) ? we_b : we_a;
         ad = (w == 1) ? addr_b : addr_a;
         dt = (w == 1) ? wdata_b : wdata_a;
         chk("m_gnt_a", gnt_a, (w == 0));
         chk("m_gnt_b", gnt_b, (w == 1));
         chk("m_wren", ram_wren, (w >= 0) && wr);
         chk("m_addr", ram_address, ad);
         if (w >= 0 && wr) chk("m_wdata", ram_data, dt);
         chk("m_owner", owner, m_state);
         if (expq.size() > 0 && expq[0].due == cyc) begin
            r = expq.pop_front();
            chk("m_rvalid_a", rvalid_a, (r.id == 0));
            chk("m_rvalid_b", rvalid_b, (r.id == 1));
            if (r.known) chk("m_rdata", rdata, r.data);
         end else begin
            chk("m_rvalid_a_idle", rvalid_a, 0);
            chk("m_rvalid_b_idle", rvalid_b, 0);
         end
         @(posedge clk);
         if (w >= 0) begin
            if (wr) begin
               mmem[ad] = dt[N-1:0];
               known[ad] = 1'b1;
            end else begin
               r.due = cyc + RD_LAT; r.id = w; r.data = mmem[ad]; r.known = known[ad];
               expq.push_back(r);
            end
         end
         if (w < 0) begin
            if (m_state != 0) m_last = m_state - 1;
            m_state = 0;
            m_cnt = 0;
         end else if (m_state == w + 1) begin
            if (m_cnt < MB) m_cnt++;
         end else begin
            if (m_state != 0) m_last = m_state - 1;
            m_state = w + 1;
            m_cnt = 1;
         end
         cyc++;
      end
   end

   task automatic cyc_set(input logic r, input logic ra, input logic wa, input logic [7:0] aa,
                          input logic [7:0] da, input logic rb, input logic wb,
                          input logic [7:0] ab, input logic [7:0] db);
      @(posedge clk);
      #1;
      rst = r; req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc_set(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
   endtask

   initial begin
      string seq;
      seq = "AAAABBBBA";
      // Requests during reset must not be granted
      cyc_set(0, 1, 0, 8'h10, 8'h00, 1, 1, 8'h03, 8'h04);
      chk("reset_gnt_a", gnt_a, 0);
      chk("reset_gnt_b", gnt_b, 0);
      chk("reset_wren", ram_wren, 0);
      idle();
      chk("idle_owner", owner, 2'b00);
      // Preload RAM through port B
      cyc_set(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5A);
      chk("pre_gnt_b0", gnt_b, 1);
      cyc_set(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h01, 8'h11);
      chk("pre_gnt_b1", gnt_b, 1);
      cyc_set(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h22);
      chk("pre_gnt_b2", gnt_b, 1);
      idle();
      // Zero-latency grant and single read
      cyc_set(1, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
      chk("t1_gnt_a", gnt_a, 1);
      chk("t1_gnt_b", gnt_b, 0);
      idle();
      chk("t1_rvalid_a", rvalid_a, 1);
      chk("t1_rdata", rdata, 8'h5A);
      chk("t1_rvalid_b", rvalid_b, 0);
      // Both ports requesting from reset: four-transfer tenures
      cyc_set(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      for (int i = 0; i < 9; i++) begin
         cyc_set(1, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
         chk("rr_seq", gnt_a ? 65 : (gnt_b ? 66 : 45), seq[i]);
         chk("rr_excl", gnt_a & gnt_b, 0);
      end
      idle();
      // Lone B keeps the grant; A wins as soon as it asks
      for (int i = 0; i < 10; i++) begin
         cyc_set(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00);
         chk("lone_gnt_b", gnt_b, 1);
      end
      cyc_set(1, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
      chk("sat_gnt_a", gnt_a, 1);
      chk("sat_gnt_b", gnt_b, 0);
      idle();
      // B write then A read of the same address
      cyc_set(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3);
      chk("wr_gnt_b", gnt_b, 1);
      cyc_set(1, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
      chk("rd_gnt_a", gnt_a, 1);
      idle();
      chk("wr_rd_rvalid_a", rvalid_a, 1);
      chk("wr_rd_rdata", rdata, 8'hC3);
      // Alternating back-to-back reads
      cyc_set(1, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
      cyc_set(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00);
      chk("alt_rvalid_a", rvalid_a, 1);
      chk("alt_rdata_a", rdata, 8'h11);
      idle();
      chk("alt_rvalid_b", rvalid_b, 1);
      chk("alt_rvalid_a_low", rvalid_a, 0);
      chk("alt_rdata_b", rdata, 8'h22);
      // Read followed by write to the same address returns the old value
      cyc_set(1, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
      cyc_set(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h77);
      chk("rbw_gnt_b", gnt_b, 1);
      chk("rbw_rvalid_a", rvalid_a, 1);
      chk("rbw_rdata", rdata, 8'h5A);
      idle();
      // Reset drops an outstanding read
      cyc_set(1, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
      chk("drop_gnt_a", gnt_a, 1);
      cyc_set(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      chk("drop_rvalid_a", rvalid_a, 0);
      chk("drop_owner", owner, 2'b00);
      cyc_set(1, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00);
      chk("post_rst_gnt_a", gnt_a, 1);
      idle();
      chk("post_rst_rvalid_a", rvalid_a, 1);
      chk("post_rst_rdata", rdata, 8'h22);
      idle();
      idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
